retospect_lif_core: RTL and testbench
=====================================

# retospect_lif_core

Leaky integrate-and-fire datapath for one neuron cell. It consumes the configuration word held by the cell's config shift chain (four 3-bit weights, 4-bit threshold, 3-bit decay select) and the 8-bit decay tick bus from the clock box. It integrates four input spike lines into a signed membrane potential and emits a one-cycle output spike when the threshold is reached. It sits directly downstream of the cell config register and the clock box, and its spike output feeds the routing fabric and the chip outbus.

## Interface
- POT_W, 6: membrane potential width, signed two's complement.
- REFRAC_CYCLES, 2: refractory length in cycles after a spike; 0 disables refractory.
- CNT_W, 8: width of the saturating fire counter.

- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- reset_nn  in  1  synchronous network reset: clears dynamic neuron state, keeps config.
- config_en  in  1  config shift in progress: freezes all dynamic state.
- spike_in  in  4  input spike lines; bit i is weighted by w[i].
- w1, w2, w3, w4  in  3 each  weights, signed two's complement (range -4..+3).
- uT  in  4  firing threshold, unsigned (range 0..15).
- decay_sel  in  3  index into clockbus selecting the leak tick.
- clockbus  in  8  decay ticks. Bit 0 is constant 0 (no leak), bit 1 is constant 1 (leak every cycle), bits 2..7 are divided ticks.
- spike_out  out  1  registered one-cycle output spike.
- pot  out  POT_W  current membrane potential (registered).
- refractory  out  1  high while in the REFRAC state.
- fire_count  out  CNT_W  saturating count of emitted spikes.

## Operation
- Control priority, highest first: reset, then reset_nn, then config_en, then normal operation.
- reset (async) and reset_nn (sync) both force:
  - pot = 0, state = INTEG, refrac counter = 0
  - spike_out = 0, fire_count = 0
- config_en = 1: pot, state, counter and fire_count hold their values; spike_out = 0; spike_in is ignored.
- The FSM has two states, INTEG and REFRAC.
- INTEG, each cycle:
  - Weighted sum: sum = pot + Σ(spike_in[i] ? sext(w[i]) : 0), computed at POT_W+2 bits signed.
  - Leak: tick = clockbus[decay_sel]. If tick = 1, sum moves one step toward 0 (sum>0 → sum−1; sum<0 → sum+1; sum=0 unchanged).
  - Saturate to the range [−2^(POT_W−1), 2^(POT_W−1)−1], i.e. [−32, 31] at the default width.
  - Fire check: if sat ≥ zero-extended uT (signed compare), then:
    - next pot = 0 and spike_out = 1 for the next cycle
    - fire_count increments, saturating at all-ones
    - the refrac counter loads REFRAC_CYCLES
    - next state = REFRAC if REFRAC_CYCLES > 0, otherwise INTEG
  - Otherwise next pot = sat and spike_out = 0.
- uT = 0 makes the neuron fire every INTEG cycle in which sat ≥ 0. This is the intended "always firing" mode.
- REFRAC, each cycle:
  - spike_in is ignored, pot is held at 0, spike_out = 0.
  - The counter decrements; when it equals 1, next state = INTEG.
- Consequence: a spike followed by refractory costs REFRAC_CYCLES dead cycles.

## Timing
- Input to spike latency: spike_in sampled at edge N → spike_out high for the cycle after edge N. Single-pulse, never held.
- pot reflects the integration result one cycle after sampling.
- Leak and inputs in the same cycle: the sum is formed first, then leak, then saturation, then compare.
- Deassertion of config_en: integration resumes on the first edge where config_en = 0, from the frozen state.
- reset_nn asserted mid-REFRAC: state returns to INTEG on the next edge and the counter clears.
- Config inputs (w*, uT, decay_sel) are treated as static outside config_en. No internal copy is taken.

## Structure
- Shared package `retospect_nn_pkg` holds:
  - the state enum (INTEG, REFRAC)
  - constants: default POT_W, weight width 3, threshold width 4
  - function `sat_add`, which performs the signed saturating resize
- One natural sub-module, `retospect_lif_accum`: the combinational weighted sum, leak and saturation. The FSM, counters and output registers stay in the top module.

## Test plan
- Reset value: after reset, pot = 0, spike_out = 0, refractory = 0, fire_count = 0. Asserting reset asynchronously mid-REFRAC clears all of them without waiting for a clock edge.
- Integrate and fire:
  - Setup: w1 = +3, uT = 7, decay_sel = 0, spike_in = 0001 held.
  - Expected: pot goes 3, then 6, then the third sample gives sat = 9 ≥ 7. spike_out pulses for one cycle, pot = 0, refractory = 1 for 2 cycles, then integration restarts.
- Leak:
  - Setup: w2 = +3, uT = 15, decay_sel = 1.
  - Stimulus: one pulse on spike_in[1], then idle.
  - Expected: pot reads 2, then decays 1, 0 and stays 0.
  - Repeat with w2 = −4: pot reads −3, then −2, −1, 0.
- Saturation:
  - Setup: all weights −4, spike_in = 1111 held, uT = 15, decay_sel = 0.
  - Expected: pot goes −16, then −32, and stays at −32 (no wrap).
- Freeze and network reset:
  - Pulse config_en for 5 cycles with pot = 6 and spike_in active: pot stays 6 and spike_out stays 0.
  - Then pulse reset_nn: pot = 0 and fire_count = 0.
- Always-fire and counter saturation:
  - Setup: uT = 0, REFRAC_CYCLES = 0, spike_in = 0.
  - Expected: spike_out is high every cycle; fire_count reaches 255 after 255 cycles and holds there.

Source files
------------

// File: rtl/retospect_nn_pkg.sv
// Shared types, widths and helpers for the retospect neuron cell datapath.
package retospect_nn_pkg;

  localparam int unsigned POT_W_DEF = 6;
  localparam int unsigned WEIGHT_W  = 3;
  localparam int unsigned THRESH_W  = 4;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_e;

  // Clamp a signed value into the representable range of a width-bit signed word.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] val,
                                                 input int unsigned      width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/retospect_lif_accum.sv
// Combinational weighted sum, one-step leak toward zero and saturation of the membrane potential.
module retospect_lif_accum
  import retospect_nn_pkg::*;
#(
  parameter int unsigned POT_W = POT_W_DEF
) (
  input  logic signed [POT_W-1:0]    pot,
  input  logic        [3:0]          spike_in,
  input  logic        [WEIGHT_W-1:0] w1,
  input  logic        [WEIGHT_W-1:0] w2,
  input  logic        [WEIGHT_W-1:0] w3,
  input  logic        [WEIGHT_W-1:0] w4,
  input  logic                       tick,
  output logic signed [POT_W-1:0]    sat
);

  localparam int unsigned SUM_W = POT_W + 2;

  logic        [WEIGHT_W-1:0] wts [4];
  logic signed [SUM_W-1:0]    sum_raw;
  logic signed [SUM_W-1:0]    sum_lk;

  assign wts[0] = w1;
  assign wts[1] = w2;
  assign wts[2] = w3;
  assign wts[3] = w4;

  always_comb begin
    sum_raw = SUM_W'(pot);
    for (int unsigned i = 0; i < 4; i++) begin
      if (spike_in[i]) begin
        sum_raw = sum_raw + SUM_W'($signed(wts[i]));
      end
    end
  end

  always_comb begin
    sum_lk = sum_raw;
    if (tick) begin
      if (sum_raw > 0) begin
        sum_lk = sum_raw - SUM_W'(1);
      end else if (sum_raw < 0) begin
        sum_lk = sum_raw + SUM_W'(1);
      end
    end
  end

  assign sat = POT_W'(sat_add(32'(sum_lk), POT_W));

endmodule

// File: rtl/retospect_lif_core.sv
// Leaky integrate-and-fire neuron: refractory FSM, fire counter and registered outputs.
module retospect_lif_core
  import retospect_nn_pkg::*;
#(
  parameter int unsigned POT_W         = POT_W_DEF,
  parameter int unsigned REFRAC_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reset_nn,
  input  logic                       config_en,
  input  logic        [3:0]          spike_in,
  input  logic        [WEIGHT_W-1:0] w1,
  input  logic        [WEIGHT_W-1:0] w2,
  input  logic        [WEIGHT_W-1:0] w3,
  input  logic        [WEIGHT_W-1:0] w4,
  input  logic        [THRESH_W-1:0] uT,
  input  logic        [2:0]          decay_sel,
  input  logic        [7:0]          clockbus,
  output logic                       spike_out,
  output logic signed [POT_W-1:0]    pot,
  output logic                       refractory,
  output logic        [CNT_W-1:0]    fire_count
);

  localparam int unsigned RC_W = (REFRAC_CYCLES < 1) ? 1 : $clog2(REFRAC_CYCLES + 1);

  lif_state_e              state_q, state_d;
  logic signed [POT_W-1:0] pot_q, pot_d;
  logic        [RC_W-1:0]  cnt_q, cnt_d;
  logic                    spike_out_q, spike_out_d;
  logic        [CNT_W-1:0] fire_count_q, fire_count_d;

  logic signed [POT_W-1:0] sat;
  logic                    tick;
  logic                    fire;

  assign tick = clockbus[decay_sel];

  retospect_lif_accum #(
    .POT_W(POT_W)
  ) u_accum (
    .pot     (pot_q),
    .spike_in(spike_in),
    .w1      (w1),
    .w2      (w2),
    .w3      (w3),
    .w4      (w4),
    .tick    (tick),
    .sat     (sat)
  );

  // Threshold is unsigned, so compare in a wide signed domain to keep negative potentials below it.
  assign fire = int'(sat) >= int'(uT);

  always_comb begin
    state_d      = state_q;
    pot_d        = pot_q;
    cnt_d        = cnt_q;
    spike_out_d  = 1'b0;
    fire_count_d = fire_count_q;
    if (reset_nn) begin
      state_d      = INTEG;
      pot_d        = '0;
      cnt_d        = '0;
      fire_count_d = '0;
    end else if (!config_en) begin
      case (state_q)
        INTEG: begin
          if (fire) begin
            pot_d        = '0;
            spike_out_d  = 1'b1;
            cnt_d        = RC_W'(REFRAC_CYCLES);
            state_d      = (REFRAC_CYCLES > 0) ? REFRAC : INTEG;
            fire_count_d = (fire_count_q == '1) ? fire_count_q : fire_count_q + CNT_W'(1);
          end else begin
            pot_d = sat;
          end
        end
        REFRAC: begin
          pot_d = '0;
          cnt_d = cnt_q - RC_W'(1);
          if (cnt_q == RC_W'(1)) begin
            state_d = INTEG;
          end
        end
        default: state_d = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INTEG;
      pot_q        <= '0;
      cnt_q        <= '0;
      spike_out_q  <= 1'b0;
      fire_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pot_q        <= pot_d;
      cnt_q        <= cnt_d;
      spike_out_q  <= spike_out_d;
      fire_count_q <= fire_count_d;
    end
  end

  assign spike_out  = spike_out_q;
  assign pot        = pot_q;
  assign refractory = (state_q == REFRAC);
  assign fire_count = fire_count_q;

endmodule

// File: tb/tb_retospect_lif_core.sv
// Self-checking bench: two cores (refractory 2 and 0) against a behavioural neuron model.
module tb_retospect_lif_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset_nn;
  logic       config_en;
  logic [3:0] spike_in;
  logic [2:0] w1, w2, w3, w4;
  logic [3:0] uT;
  logic [2:0] decay_sel;
  logic [7:0] clockbus;

  logic       spk_o [2];
  logic [5:0] pot_o [2];
  logic       ref_o [2];
  logic [7:0] cnt_o [2];

  int checks   = 0;
  int failures = 0;

  int m_pot  [2];
  int m_dead [2];
  int m_cnt  [2];
  bit m_spk  [2];

  always #5 clk = ~clk;

  retospect_lif_core #(.POT_W(6), .REFRAC_CYCLES(2), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .reset_nn(reset_nn), .config_en(config_en),
    .spike_in(spike_in), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .uT(uT),
    .decay_sel(decay_sel), .clockbus(clockbus),
    .spike_out(spk_o[0]), .pot(pot_o[0]), .refractory(ref_o[0]), .fire_count(cnt_o[0])
  );

  retospect_lif_core #(.POT_W(6), .REFRAC_CYCLES(0), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .reset_nn(reset_nn), .config_en(config_en),
    .spike_in(spike_in), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .uT(uT),
    .decay_sel(decay_sel), .clockbus(clockbus),
    .spike_out(spk_o[1]), .pot(pot_o[1]), .refractory(ref_o[1]), .fire_count(cnt_o[1])
  );

  function automatic int sx3(input logic [2:0] v);
    return v[2] ? int'(v) - 8 : int'(v);
  endfunction

  function automatic int refrac_len(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_pot[k] = 0; m_dead[k] = 0; m_cnt[k] = 0; m_spk[k] = 0;
    end
  endtask

  // Neuron behaviour for one clock edge, from the inputs present just before the edge.
  task automatic model_step();
    int wv [4];
    int s;
    wv[0] = sx3(w1); wv[1] = sx3(w2); wv[2] = sx3(w3); wv[3] = sx3(w4);
    for (int k = 0; k < 2; k++) begin
      if (reset_nn) begin
        m_pot[k] = 0; m_dead[k] = 0; m_cnt[k] = 0; m_spk[k] = 0;
      end else if (config_en) begin
        m_spk[k] = 0;
      end else if (m_dead[k] > 0) begin
        m_dead[k]--; m_pot[k] = 0; m_spk[k] = 0;
      end else begin
        s = m_pot[k];
        for (int i = 0; i < 4; i++) if (spike_in[i]) s += wv[i];
        if (clockbus[decay_sel]) s = (s > 0) ? s - 1 : (s < 0) ? s + 1 : 0;
        if (s > 31) s = 31;
        if (s < -32) s = -32;
        if (s >= int'(uT)) begin
          m_pot[k] = 0; m_spk[k] = 1; m_dead[k] = refrac_len(k);
          if (m_cnt[k] < 255) m_cnt[k]++;
        end else begin
          m_pot[k] = s; m_spk[k] = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    clockbus = {6'($urandom), 2'b10};
  endtask

  task automatic nn_reset();
    reset_nn = 1'b1;
    cyc();
    reset_nn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_nn = 1'b0; config_en = 1'b0; spike_in = '0;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0; uT = 4'd15; decay_sel = '0;
    clockbus = 8'b0000_0010;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pot_o[k] !== 6'd0 || spk_o[k] !== 1'b0 || ref_o[k] !== 1'b0 || cnt_o[k] !== 8'd0) begin
        failures++;
        $display("FAIL reset inst=%0d pot=%0d spk=%0b ref=%0b cnt=%0d want all 0",
                 k, $signed(pot_o[k]), spk_o[k], ref_o[k], cnt_o[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_integrate_fire();
    int exp_pot [6] = '{3, 6, 0, 0, 0, 3};
    bit exp_spk [6] = '{0, 0, 1, 0, 0, 0};
    bit exp_ref [6] = '{0, 0, 1, 1, 0, 0};
    nn_reset();
    w1 = 3'd3; w2 = 3'($urandom); w3 = 3'($urandom); w4 = 3'($urandom);
    uT = 4'd7; decay_sel = 3'd0; spike_in = 4'b0001;
    for (int n = 0; n < 6; n++) begin
      cyc();
      checks++;
      if ($signed(pot_o[0]) !== exp_pot[n] || spk_o[0] !== exp_spk[n] || ref_o[0] !== exp_ref[n]) begin
        failures++;
        $display("FAIL integ_fire step=%0d pot=%0d/%0d spk=%0b/%0b ref=%0b/%0b", n,
                 $signed(pot_o[0]), exp_pot[n], spk_o[0], exp_spk[n], ref_o[0], exp_ref[n]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ($signed(pot_o[k]) !== m_pot[k] || spk_o[k] !== m_spk[k] ||
            ref_o[k] !== (m_dead[k] > 0) || cnt_o[k] !== m_cnt[k]) begin
          failures++;
          $display("FAIL integ_fire_model inst=%0d pot=%0d/%0d spk=%0b/%0b cnt=%0d/%0d", k,
                   $signed(pot_o[k]), m_pot[k], spk_o[k], m_spk[k], cnt_o[k], m_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_leak();
    int exp_pos [5] = '{2, 1, 0, 0, 0};
    int exp_neg [5] = '{-3, -2, -1, 0, 0};
    for (int pass = 0; pass < 2; pass++) begin
      nn_reset();
      w1 = '0; w3 = '0; w4 = '0;
      w2 = (pass == 0) ? 3'd3 : 3'b100;
      uT = 4'd15; decay_sel = 3'd1;
      for (int n = 0; n < 5; n++) begin
        spike_in = (n == 0) ? 4'b0010 : 4'b0000;
        cyc();
        checks++;
        if ($signed(pot_o[0]) !== ((pass == 0) ? exp_pos[n] : exp_neg[n]) ||
            $signed(pot_o[0]) !== m_pot[0]) begin
          failures++;
          $display("FAIL leak pass=%0d step=%0d pot=%0d want=%0d", pass, n,
                   $signed(pot_o[0]), (pass == 0) ? exp_pos[n] : exp_neg[n]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int exp_pot [4] = '{-16, -32, -32, -32};
    nn_reset();
    w1 = 3'b100; w2 = 3'b100; w3 = 3'b100; w4 = 3'b100;
    uT = 4'd15; decay_sel = 3'd0; spike_in = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ($signed(pot_o[k]) !== exp_pot[n] || $signed(pot_o[k]) !== m_pot[k] || spk_o[k] !== 1'b0) begin
          failures++;
          $display("FAIL saturation inst=%0d step=%0d pot=%0d want=%0d spk=%0b", k, n,
                   $signed(pot_o[k]), exp_pot[n], spk_o[k]);
        end
      end
    end
  endtask

  task automatic test_freeze_nn_reset();
    nn_reset();
    w1 = 3'd3; w2 = '0; w3 = '0; w4 = '0; uT = 4'd7; decay_sel = 3'd0; spike_in = 4'b0001;
    repeat (7) cyc();
    config_en = 1'b1; spike_in = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cyc();
      checks++;
      if ($signed(pot_o[0]) !== 6 || spk_o[0] !== 1'b0 || cnt_o[0] !== 8'd1 ||
          $signed(pot_o[0]) !== m_pot[0]) begin
        failures++;
        $display("FAIL freeze step=%0d pot=%0d want=6 spk=%0b want=0 cnt=%0d want=1", n,
                 $signed(pot_o[0]), spk_o[0], cnt_o[0]);
      end
    end
    config_en = 1'b0; spike_in = 4'b0000;
    nn_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pot_o[k] !== 6'd0 || cnt_o[k] !== 8'd0 || spk_o[k] !== 1'b0 || ref_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL nn_reset inst=%0d pot=%0d cnt=%0d spk=%0b ref=%0b want all 0", k,
                 $signed(pot_o[k]), cnt_o[k], spk_o[k], ref_o[k]);
      end
    end
  endtask

  task automatic test_async_reset_refrac();
    nn_reset();
    uT = 4'd0; spike_in = 4'b0000; decay_sel = 3'd0;
    cyc();
    checks++;
    if (ref_o[0] !== 1'b1 || spk_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL refrac_entry ref=%0b spk=%0b want 1 1", ref_o[0], spk_o[0]);
    end
    #2 reset = 1'b1;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pot_o[k] !== 6'd0 || spk_o[k] !== 1'b0 || ref_o[k] !== 1'b0 || cnt_o[k] !== 8'd0) begin
        failures++;
        $display("FAIL async_reset inst=%0d pot=%0d spk=%0b ref=%0b cnt=%0d want all 0", k,
                 $signed(pot_o[k]), spk_o[k], ref_o[k], cnt_o[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    uT = 4'd15;
  endtask

  task automatic test_always_fire();
    nn_reset();
    uT = 4'd0; spike_in = 4'b0000; decay_sel = 3'($urandom);
    for (int n = 1; n <= 260; n++) begin
      cyc();
      checks++;
      if (spk_o[1] !== 1'b1 || cnt_o[1] !== 8'((n > 255) ? 255 : n)) begin
        failures++;
        $display("FAIL always_fire cycle=%0d spk=%0b want=1 cnt=%0d want=%0d", n, spk_o[1],
                 cnt_o[1], (n > 255) ? 255 : n);
      end
      checks++;
      if (spk_o[0] !== m_spk[0] || cnt_o[0] !== m_cnt[0] || ref_o[0] !== (m_dead[0] > 0)) begin
        failures++;
        $display("FAIL always_fire_refrac cycle=%0d spk=%0b/%0b cnt=%0d/%0d", n, spk_o[0],
                 m_spk[0], cnt_o[0], m_cnt[0]);
      end
    end
  endtask

  task automatic test_random();
    nn_reset();
    for (int n = 0; n < 600; n++) begin
      spike_in  = 4'($urandom);
      reset_nn  = ($urandom_range(0, 39) == 0);
      config_en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) begin
        w1 = 3'($urandom); w2 = 3'($urandom); w3 = 3'($urandom); w4 = 3'($urandom);
        uT = 4'($urandom); decay_sel = 3'($urandom);
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ($signed(pot_o[k]) !== m_pot[k] || spk_o[k] !== m_spk[k] ||
            ref_o[k] !== (m_dead[k] > 0) || cnt_o[k] !== m_cnt[k]) begin
          failures++;
          $display("FAIL random n=%0d inst=%0d pot=%0d/%0d spk=%0b/%0b ref=%0b/%0b cnt=%0d/%0d",
                   n, k, $signed(pot_o[k]), m_pot[k], spk_o[k], m_spk[k], ref_o[k],
                   (m_dead[k] > 0), cnt_o[k], m_cnt[k]);
        end
      end
    end
    reset_nn = 1'b0; config_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_integrate_fire();
    test_leak();
    test_saturation();
    test_freeze_nn_reset();
    test_async_reset_refrac();
    test_always_fire();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
